pixel_fetch: RTL and testbench

Video byte fetcher on the display path. It walks video RAM one scanline at a time and requests bytes over a simple req/ack memory port. Each byte goes into a one-byte prefetch buffer, then is presented to the pixel shift register as `outData` with a one-cycle `load` strobe on every byte boundary of the active line. It is the producer end of the shifter's `inData`/`load`/`divider` interface and runs on the same pixel clock.

---
 rtl/pixel_fetch_pkg.sv | 20 ++
 rtl/pixel_fetch_line_counter.sv | 51 +++++
 rtl/pixel_fetch.sv | 124 ++++++++++++
 tb/tb_pixel_fetch.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pixel_fetch_pkg.sv
// Shared definitions for the video byte fetcher: fetch FSM states,
// default address width and pixels-per-byte constants.
package pixel_fetch_pkg;

  localparam int ADDR_W_DEF        = 16;
  localparam int PIX_PER_BYTE_1BPP = 8;
  localparam int PIX_PER_BYTE_2BPP = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_FULL = 2'd2
  } fetch_state_t;

  // A row repeat of zero behaves like one scanline per row.
  function automatic logic [3:0] row_repeat_eff(input logic [3:0] rep);
    return (rep == 4'd0) ? 4'd1 : rep;
  endfunction

endpackage

// File: rtl/pixel_fetch_line_counter.sv
// Tracks the scanline count within a fetched row and the start address
// of the current row; advances the row on the falling edge of hActive.
module pixel_fetch_line_counter
  import pixel_fetch_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_frame_start,
  input  logic              i_h_active,
  input  logic [ADDR_W-1:0] i_base_addr,
  input  logic [5:0]        i_bytes_per_line,
  input  logic [3:0]        i_row_repeat,
  output logic [ADDR_W-1:0] o_line_addr
);

  logic [3:0]        r_row_cnt;
  logic [ADDR_W-1:0] r_line_addr;
  logic              r_h_active_d;
  logic              w_row_end;
  logic [3:0]        w_row_next;

  assign w_row_end  = r_h_active_d && !i_h_active;
  assign w_row_next = r_row_cnt + 4'd1;

  // frameStart has priority over a row advance in the same cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      r_row_cnt    <= 4'd0;
      r_line_addr  <= '0;
      r_h_active_d <= 1'b0;
    end else begin
      r_h_active_d <= i_h_active;
      if (i_frame_start) begin
        r_line_addr <= i_base_addr;
        r_row_cnt   <= 4'd0;
      end else if (w_row_end) begin
        if (w_row_next == row_repeat_eff(i_row_repeat)) begin
          r_row_cnt   <= 4'd0;
          r_line_addr <= r_line_addr + ADDR_W'(i_bytes_per_line);
        end else begin
          r_row_cnt <= w_row_next;
        end
      end
    end
  end

  assign o_line_addr = r_line_addr;

endmodule

// File: rtl/pixel_fetch.sv
// Video byte fetcher: one-byte prefetch from video RAM over req/ack and
// a load strobe to the pixel shifter on every byte boundary of the line.
//
//   state  | meaning
//   S_IDLE | buffer empty, no request outstanding
//   S_REQ  | request outstanding, memReq/memAddr held until memAck
//   S_FULL | prefetch buffer holds the next byte
module pixel_fetch
  import pixel_fetch_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              divider,
  input  logic              frameStart,
  input  logic              lineStart,
  input  logic              hActive,
  input  logic [ADDR_W-1:0] baseAddr,
  input  logic [5:0]        bytesPerLine,
  input  logic [3:0]        rowRepeat,
  output logic              memReq,
  output logic [ADDR_W-1:0] memAddr,
  input  logic              memAck,
  input  logic [7:0]        memData,
  output logic [7:0]        outData,
  output logic              load,
  output logic              underrun
);

  fetch_state_t      r_state, w_state_next;
  logic [ADDR_W-1:0] r_addr, r_mem_addr, w_line_addr;
  logic [5:0]        r_fetched, r_loaded;
  logic [2:0]        r_phase, w_phase_last;
  logic [7:0]        r_buf, r_out_data;
  logic              r_div, r_stale, r_load, r_underrun;
  logic              w_buf_valid, w_line_active, w_load_evt, w_ack, w_ack_keep;

  pixel_fetch_line_counter #(.ADDR_W(ADDR_W)) u_line_counter (
    .clk              (clk),
    .rst              (rst),
    .i_frame_start    (frameStart),
    .i_h_active       (hActive),
    .i_base_addr      (baseAddr),
    .i_bytes_per_line (bytesPerLine),
    .i_row_repeat     (rowRepeat),
    .o_line_addr      (w_line_addr)
  );

  assign w_buf_valid   = (r_state == S_FULL);
  assign w_line_active = hActive && !lineStart && (r_loaded < bytesPerLine);
  assign w_load_evt    = w_line_active && (r_phase == 3'd0);
  assign w_ack         = memAck && (r_state == S_REQ);
  // A request straddling lineStart still completes, but its byte belongs
  // to the previous line and is dropped.
  assign w_ack_keep    = w_ack && !lineStart && !r_stale;
  assign w_phase_last  = r_div ? 3'(PIX_PER_BYTE_2BPP - 1) : 3'(PIX_PER_BYTE_1BPP - 1);

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: if (!lineStart && (r_fetched < bytesPerLine)) w_state_next = S_REQ;
      S_REQ:  if (w_ack) w_state_next = (w_ack_keep && !w_load_evt) ? S_FULL : S_IDLE;
      S_FULL: if (lineStart || w_load_evt) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr     <= '0;
      r_mem_addr <= '0;
      r_fetched  <= 6'd0;
      r_loaded   <= 6'd0;
      r_phase    <= 3'd0;
      r_buf      <= 8'h00;
      r_out_data <= 8'h00;
      r_div      <= 1'b0;
      r_stale    <= 1'b0;
      r_load     <= 1'b0;
      r_underrun <= 1'b0;
    end else begin
      if ((r_state == S_IDLE) && (w_state_next == S_REQ)) r_mem_addr <= r_addr;
      if (lineStart) begin
        r_addr    <= w_line_addr;
        r_fetched <= 6'd0;
        r_loaded  <= 6'd0;
        r_phase   <= 3'd0;
        r_div     <= divider;
        r_stale   <= (r_state == S_REQ) && !memAck;
      end else begin
        if (w_ack) r_stale <= 1'b0;
        if (w_ack_keep) begin
          r_buf     <= memData;
          r_addr    <= r_addr + ADDR_W'(1);
          r_fetched <= r_fetched + 6'd1;
        end
        if (w_line_active) begin
          r_phase <= (r_phase == w_phase_last) ? 3'd0 : r_phase + 3'd1;
          if (w_load_evt) r_loaded <= r_loaded + 6'd1;
        end
      end
      r_load     <= w_load_evt;
      r_underrun <= w_load_evt && !w_buf_valid && !w_ack_keep;
      // Empty buffer: take the coinciding ack directly, otherwise emit zero.
      if (w_load_evt)
        r_out_data <= w_buf_valid ? r_buf : (w_ack_keep ? memData : 8'h00);
    end
  end

  always_comb begin
    memReq   = (r_state == S_REQ);
    memAddr  = r_mem_addr;
    outData  = r_out_data;
    load     = r_load;
    underrun = r_underrun;
  end

endmodule

// File: tb/tb_pixel_fetch.sv
// Self-checking bench for pixel_fetch: random video RAM, a latency-
// programmable memory responder and a per-line reference of load timing/data.
module tb_pixel_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        divider = 1'b0, frameStart = 1'b0, lineStart = 1'b0, hActive = 1'b0;
  logic [15:0] baseAddr = 16'h0;
  logic [5:0]  bytesPerLine = 6'd0;
  logic [3:0]  rowRepeat = 4'd1;
  logic        memReq, memAck, load, underrun;
  logic [15:0] memAddr;
  logic [7:0]  memData, outData;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [7:0]  vmem [0:65535];
  bit          mem_en = 1'b0;
  int          mem_lat = 0;
  int          wcnt = 0;
  logic [15:0] req_addr = 16'h0;
  logic        resp_ack = 1'b0, man_ack = 1'b0;
  logic [7:0]  resp_data = 8'h0, man_data = 8'h0;
  int          ack_edge[$];
  logic [15:0] ack_addr[$];
  int          ld_edge[$];
  logic [7:0]  ld_data[$];
  logic        ld_ur[$];
  int          stab_err = 0, spur_err = 0, glitch_err = 0;
  logic [7:0]  prev_out = 8'h0;
  logic [15:0] m_line_addr = 16'h0;
  int          m_row = 0;

  assign memAck  = mem_en ? resp_ack  : man_ack;
  assign memData = mem_en ? resp_data : man_data;

  pixel_fetch #(.ADDR_W(16)) dut (
    .clk(clk), .rst(rst), .divider(divider), .frameStart(frameStart),
    .lineStart(lineStart), .hActive(hActive), .baseAddr(baseAddr),
    .bytesPerLine(bytesPerLine), .rowRepeat(rowRepeat), .memReq(memReq),
    .memAddr(memAddr), .memAck(memAck), .memData(memData), .outData(outData),
    .load(load), .underrun(underrun)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory: ack mem_lat cycles after memReq is first seen; ack lands on edge cyc+1.
  always @(negedge clk) begin
    resp_ack = 1'b0;
    if (mem_en && memReq === 1'b1) begin
      if (wcnt == 0) req_addr = memAddr;
      else if (memAddr !== req_addr) stab_err++;
      if (wcnt >= mem_lat) begin
        resp_ack  = 1'b1;
        resp_data = vmem[memAddr];
        ack_edge.push_back(cyc + 1);
        ack_addr.push_back(memAddr);
        wcnt = 0;
      end else begin
        wcnt++;
      end
    end else begin
      wcnt = 0;
    end
  end

  always @(negedge clk) begin
    if (load === 1'b1) begin
      ld_edge.push_back(cyc);
      ld_data.push_back(outData);
      ld_ur.push_back(underrun);
    end
    if (underrun === 1'b1 && load !== 1'b1) spur_err++;
    if (rst === 1'b0 && load !== 1'b1 && outData !== prev_out) glitch_err++;
    prev_out = outData;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_frame(input logic [15:0] b);
    @(negedge clk);
    baseAddr = b; frameStart = 1'b1;
    @(negedge clk);
    frameStart = 1'b0;
    m_line_addr = b; m_row = 0;
  endtask

  // One scanline; expected loads: first on the edge sampling hActive=1, then every
  // 8/4 edges. Each load takes the oldest acked byte (ack on or before that edge),
  // else it is an underrun with 0x00.
  task automatic run_line(input int nb, input bit div, input int lat, input logic [3:0] rep,
                          input string tag, output logic [15:0] first_addr, output int n_obs_ur);
    int p, h0, j, e, n_ur;
    logic [7:0]  exp_d;
    logic        exp_u;
    logic [15:0] base;
    p = div ? 4 : 8;
    base = m_line_addr;
    @(negedge clk);
    ack_edge.delete(); ack_addr.delete();
    ld_edge.delete(); ld_data.delete(); ld_ur.delete();
    stab_err = 0; spur_err = 0; glitch_err = 0;
    bytesPerLine = 6'(nb); divider = div; rowRepeat = rep; mem_lat = lat; mem_en = 1'b1;
    lineStart = 1'b1;
    @(negedge clk);
    lineStart = 1'b0;
    tick(6);
    hActive = 1'b1;
    h0 = cyc + 1;
    tick(nb * p + 4);
    hActive = 1'b0;
    tick(2 * lat + p + 12);
    m_row++;
    if (m_row == ((rep == 4'd0) ? 1 : int'(rep))) begin
      m_row = 0;
      m_line_addr = 16'(m_line_addr + nb);
    end

    checks++;
    if (ld_edge.size() != nb) begin
      errors++;
      $display("FAIL %s load_count got %0d want %0d", tag, ld_edge.size(), nb);
    end
    j = 0; n_ur = 0; n_obs_ur = 0;
    for (int i = 0; i < nb; i++) begin
      e = h0 + i * p;
      if (j < ack_edge.size() && ack_edge[j] <= e) begin
        exp_d = vmem[16'(base + j)]; exp_u = 1'b0; j++;
      end else begin
        exp_d = 8'h00; exp_u = 1'b1; n_ur++;
      end
      if (i < ld_edge.size()) begin
        if (ld_ur[i] === 1'b1) n_obs_ur++;
        checks++;
        if (ld_edge[i] != e) begin
          errors++;
          $display("FAIL %s load_time[%0d] got %0d want %0d", tag, i, ld_edge[i], e);
        end
        checks++;
        if (ld_data[i] !== exp_d) begin
          errors++;
          $display("FAIL %s outData[%0d] got %02h want %02h", tag, i, ld_data[i], exp_d);
        end
        checks++;
        if (ld_ur[i] !== exp_u) begin
          errors++;
          $display("FAIL %s underrun[%0d] got %0b want %0b", tag, i, ld_ur[i], exp_u);
        end
      end
    end
    for (int k = 0; k < ack_addr.size(); k++) begin
      checks++;
      if (ack_addr[k] !== 16'(base + k)) begin
        errors++;
        $display("FAIL %s memAddr[%0d] got %04h want %04h", tag, k, ack_addr[k], 16'(base + k));
      end
    end
    if (n_ur == 0) begin
      checks++;
      if (ack_addr.size() != nb) begin
        errors++;
        $display("FAIL %s fetch_count got %0d want %0d", tag, ack_addr.size(), nb);
      end
    end
    checks++;
    if (stab_err != 0 || spur_err != 0 || glitch_err != 0) begin
      errors++;
      $display("FAIL %s protocol got stab=%0d spur=%0d glitch=%0d want all 0",
               tag, stab_err, spur_err, glitch_err);
    end
    first_addr = (ack_addr.size() > 0) ? ack_addr[0] : 16'h0000;
  endtask

  task automatic test_reset;
    bit seen;
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(2);
    checks++;
    if (memReq !== 1'b0 || memAddr !== 16'h0 || outData !== 8'h00 || load !== 1'b0 || underrun !== 1'b0) begin
      errors++;
      $display("FAIL reset_values got req=%b addr=%h out=%h load=%b ur=%b want 0/0000/00/0/0",
               memReq, memAddr, outData, load, underrun);
    end
    do_frame(16'h0400);
    @(negedge clk);
    bytesPerLine = 6'd4; divider = 1'b0; mem_lat = 50; mem_en = 1'b1;
    lineStart = 1'b1;
    @(negedge clk);
    lineStart = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      seen = (memReq === 1'b1);
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL reset_req_wait got memReq=%b want 1 within 20 cycles", memReq);
    end
    tick(2);
    rst = 1'b1; mem_en = 1'b0; man_ack = 1'b0; bytesPerLine = 6'd0;
    tick(1);
    checks++;
    if (memReq !== 1'b0 || outData !== 8'h00 || memAddr !== 16'h0) begin
      errors++;
      $display("FAIL reset_mid_req got req=%b out=%h addr=%h want 0/00/0000", memReq, outData, memAddr);
    end
    tick(2);
    rst = 1'b0;
    man_ack = 1'b1; man_data = 8'hAB;
    tick(2);
    man_ack = 1'b0;
    bytesPerLine = 6'd1; hActive = 1'b1;
    tick(1);
    hActive = 1'b0;
    checks++;
    if (load !== 1'b1 || underrun !== 1'b1 || outData !== 8'h00) begin
      errors++;
      $display("FAIL late_ack_ignored got load=%b ur=%b out=%h want 1/1/00", load, underrun, outData);
    end
    checks++;
    if (memReq !== 1'b1 || memAddr !== 16'h0000) begin
      errors++;
      $display("FAIL post_reset_addr got req=%b addr=%h want 1/0000", memReq, memAddr);
    end
    rst = 1'b1; bytesPerLine = 6'd0;
    tick(2);
    rst = 1'b0;
    m_line_addr = 16'h0; m_row = 0;
  endtask

  task automatic test_1bpp;
    logic [15:0] fa; int nur;
    do_frame(16'h0400);
    run_line(32, 1'b0, 0, 4'd1, "1bpp", fa, nur);
    checks++;
    if (fa !== 16'h0400 || nur != 0) begin
      errors++;
      $display("FAIL 1bpp_start got addr=%h ur=%0d want 0400/0", fa, nur);
    end
  endtask

  task automatic test_2bpp;
    logic [15:0] fa; int nur;
    do_frame(16'h0400);
    run_line(32, 1'b1, 2, 4'd1, "2bpp", fa, nur);
    checks++;
    if (fa !== 16'h0400 || nur != 0) begin
      errors++;
      $display("FAIL 2bpp_start got addr=%h ur=%0d want 0400/0", fa, nur);
    end
  endtask

  task automatic test_slow;
    logic [15:0] fa; int nur;
    do_frame(16'h0800);
    run_line(20, 1'b1, 6, 4'd1, "slow", fa, nur);
    checks++;
    if (nur == 0) begin
      errors++;
      $display("FAIL slow_underrun got %0d pulses want >0", nur);
    end
  endtask

  task automatic test_row_repeat;
    logic [15:0] fa, want; int nur;
    do_frame(16'h0400);
    for (int l = 0; l < 4; l++) begin
      run_line(16, 1'b1, 1, 4'd3, "rowrep", fa, nur);
      want = (l < 3) ? 16'h0400 : 16'h0410;
      checks++;
      if (fa !== want) begin
        errors++;
        $display("FAIL rowrep_line%0d got %h want %h", l, fa, want);
      end
    end
    do_frame(16'h0400);
    run_line(16, 1'b1, 1, 4'd3, "rowrep_frame", fa, nur);
    checks++;
    if (fa !== 16'h0400) begin
      errors++;
      $display("FAIL rowrep_frame got %h want 0400", fa);
    end
  endtask

  task automatic test_wrap;
    logic [15:0] fa; int nur;
    do_frame(16'hFFF8);
    run_line(16, 1'b0, 0, 4'd1, "wrap", fa, nur);
    checks++;
    if (fa !== 16'hFFF8 || nur != 0) begin
      errors++;
      $display("FAIL wrap_start got addr=%h ur=%0d want FFF8/0", fa, nur);
    end
  endtask

  task automatic test_edges;
    logic [15:0] fa; int nur;
    do_frame(16'h1000);
    run_line(0, 1'b0, 0, 4'd0, "zero_bytes", fa, nur);
    run_line(8, 1'b1, 0, 4'd0, "rep0_a", fa, nur);
    run_line(8, 1'b1, 0, 4'd0, "rep0_b", fa, nur);
    checks++;
    if (fa !== 16'h1008) begin
      errors++;
      $display("FAIL rep0_advance got %h want 1008", fa);
    end
  endtask

  task automatic test_random;
    logic [15:0] fa; int nur;
    do_frame(16'($urandom));
    for (int l = 0; l < 6; l++)
      run_line(int'($urandom_range(1, 63)), 1'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
               4'($urandom_range(0, 3)), "random", fa, nur);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog got running want finished");
    $fatal(1, "timeout");
  end

  initial begin
    for (int a = 0; a < 65536; a++) vmem[a] = 8'($urandom);
    test_reset();
    test_1bpp();
    test_2bpp();
    test_slow();
    test_row_repeat();
    test_wrap();
    test_edges();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
